// File: rtl/adc_responder.sv
// rtl/adc_responder.sv - behavioural parallel-ADC responder (convStart/busy/rd_cs/adcVoltage)
// Optional feature: define RAMP_GEN_EN to convert an internal ramp instead of sampleIn.
module adc_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int CONV_CYCLES = 8
`ifdef RAMP_GEN_EN
  , parameter int RAMP_STEP = 1
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  convStart,
  input  logic                  rd_cs,
  input  logic [DATA_WIDTH-1:0] sampleIn,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] adcVoltage,
  output logic                  convOverrun
);

  typedef enum logic {IDLE, CONV} stateType;

  localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);

  stateType              state, stateNext;
  logic [7:0]            counter, counterNext;
  logic                  busyNext;
  logic                  convStartPrev;
  logic                  startEdge;
  logic                  startConv;
  logic                  convDone;
  logic                  overrunSet;
  logic [DATA_WIDTH-1:0] holdReg;
  logic [DATA_WIDTH-1:0] resultReg;
  logic [DATA_WIDTH-1:0] captureValue;

  assign startEdge = convStartPrev & ~convStart;

`ifdef RAMP_GEN_EN
  logic [DATA_WIDTH-1:0] ramp;
  logic                  unusedSample;

  assign unusedSample = ^sampleIn;
  assign captureValue = ramp;

  always_ff @(posedge clk) begin
    if (reset) begin
      ramp <= '0;
    end else if (convDone) begin
      ramp <= ramp + DATA_WIDTH'(RAMP_STEP);
    end
  end
`else
  assign captureValue = sampleIn;
`endif

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    busyNext    = busy;
    startConv   = 1'b0;
    convDone    = 1'b0;
    overrunSet  = 1'b0;
    case (state)
      IDLE: begin
        if (startEdge) begin
          startConv   = 1'b1;
          counterNext = CONV_LOAD;
          busyNext    = 1'b1;
          stateNext   = CONV;
        end
      end
      CONV: begin
        // A request in the completion cycle is still an overrun: we are in CONV.
        overrunSet = startEdge;
        if (counter == 8'd0) begin
          convDone  = 1'b1;
          busyNext  = 1'b0;
          stateNext = IDLE;
        end else begin
          counterNext = counter - 8'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= 8'd0;
      busy        <= 1'b0;
      holdReg     <= '0;
      resultReg   <= '0;
      adcVoltage  <= '0;
      convOverrun <= 1'b0;
      // Track the pin through reset so a line held low across release is not an edge.
      convStartPrev <= convStart;
    end else begin
      state         <= stateNext;
      counter       <= counterNext;
      busy          <= busyNext;
      convStartPrev <= convStart;
      if (startConv) holdReg <= captureValue;
      if (convDone) resultReg <= holdReg;
      if (overrunSet) convOverrun <= 1'b1;
      adcVoltage <= rd_cs ? '0 : resultReg;
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// tb/tb_adc_responder.sv - scoreboard bench for adc_responder (RAMP_GEN_EN selects the ramp run)
module tb_adc_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       convStart = 1'b1;
  logic       rd_cs = 1'b1;
  logic [7:0] sampleIn = 8'h00;
  logic       busy;
  logic [7:0] adcVoltage;
  logic       convOverrun;

  typedef struct {
    logic       busy;
    logic [7:0] adc;
    logic       ovr;
    string      name;
  } expType;

  expType expQ[$];
  int     nChecks = 0;
  int     nFails  = 0;

  adc_responder dut (
    .clk        (clk),
    .reset      (reset),
    .convStart  (convStart),
    .rd_cs      (rd_cs),
    .sampleIn   (sampleIn),
    .busy       (busy),
    .adcVoltage (adcVoltage),
    .convOverrun(convOverrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: after every active edge, pop what the stimulus predicted for it.
  initial begin
    expType e;
    forever begin
      @(posedge clk);
      #1;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        check({e.name, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
        check({e.name, ".adc"}, adcVoltage, e.adc);
        check({e.name, ".ovr"}, {7'd0, convOverrun}, {7'd0, e.ovr});
      end
    end
  end

  task automatic cyc(input logic rst, input logic cs, input logic rd, input logic [7:0] s,
                     input logic eb, input logic [7:0] ea, input logic eo, input string nm);
    expType e;
    @(negedge clk);
    reset     = rst;
    convStart = cs;
    rd_cs     = rd;
    sampleIn  = s;
    e.busy = eb;
    e.adc  = ea;
    e.ovr  = eo;
    e.name = nm;
    expQ.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 1, 1, 8'h00, 0, 8'h00, 0, "reset0");
    cyc(1, 1, 1, 8'h00, 0, 8'h00, 0, "reset1");
`ifdef RAMP_GEN_EN
    for (int n = 0; n < 257; n++) begin
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'hEE, 1, 8'h00, 0, "rampBusy");
      cyc(0, 1, 1, 8'hEE, 0, 8'h00, 0, "rampDone");
      cyc(0, 1, 0, 8'hEE, 0, 8'(n % 256), 0, "rampRead");
    end
`else
    // Basic conversion of A5; sampleIn changes after capture and must not matter.
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, (i == 0) ? 8'hA5 : 8'h5A, 1, 8'h00, 0, "convA5");
    cyc(0, 1, 1, 8'h5A, 0, 8'h00, 0, "dropA5");
    cyc(0, 1, 0, 8'h5A, 0, 8'hA5, 0, "readA5");
    cyc(0, 1, 1, 8'h5A, 0, 8'h00, 0, "releaseA5");

    // Second request three cycles in: overrun, same busy length, result unchanged.
    for (int i = 0; i < 8; i++)
      cyc(0, (i == 1) ? 1'b1 : 1'b0, 1, (i == 0) ? 8'h3C : 8'h77, 1, 8'h00, (i >= 2), "overrun");
    cyc(0, 1, 1, 8'h77, 0, 8'h00, 1, "dropOvr");
    cyc(0, 1, 0, 8'h77, 0, 8'h3C, 1, "read3C");

    // convStart held low across reset release: no conversion; overrun cleared.
    cyc(1, 0, 1, 8'h11, 0, 8'h00, 0, "rstLow0");
    cyc(1, 0, 1, 8'h11, 0, 8'h00, 0, "rstLow1");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h11, 0, 8'h00, 0, "heldLow");
    cyc(0, 1, 1, 8'h11, 0, 8'h00, 0, "rise");

    // Store 11, then convert 22 while reading throughout.
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'h11, 1, 8'h00, 0, "conv11");
    cyc(0, 1, 1, 8'h11, 0, 8'h00, 0, "drop11");
    cyc(0, 1, 0, 8'h22, 0, 8'h11, 0, "read11");
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h22, 1, 8'h11, 0, "conv22old");
    cyc(0, 1, 0, 8'h22, 0, 8'h11, 0, "complete22old");
    cyc(0, 1, 0, 8'h22, 0, 8'h22, 0, "after22new");

    // Reset at busy cycle 4, with an overrun already flagged.
    cyc(0, 0, 0, 8'h99, 1, 8'h22, 0, "abort1");
    cyc(0, 1, 0, 8'h99, 1, 8'h22, 0, "abort2");
    cyc(0, 0, 0, 8'h99, 1, 8'h22, 1, "abort3");
    cyc(1, 1, 0, 8'h99, 0, 8'h00, 0, "abortRst");
    cyc(0, 1, 0, 8'h99, 0, 8'h00, 0, "readAfterAbort");
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'h99, 0, 8'h00, 0, "idleAfterAbort");
`endif
    @(negedge clk);
    @(negedge clk);
    check("scoreboardDrained", 8'(expQ.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
